// File: rtl/bram_port_if.sv
// Single BRAM port: write enable, address, write data and registered read data.
// The controller drives the master side; the memory drives dout one cycle after addr.
interface bram_port_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output we, output addr, output din, input dout);
    modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO over an external dual-port BRAM with a 2-entry output buffer.
// Optional synchronous clear port i_flush when BRAM_STREAM_FIFO_FLUSH_EN is defined.
module bram_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
`ifdef BRAM_STREAM_FIFO_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [ADDR_WIDTH+1:0] o_count,
    bram_port_if.master           port_a,
    bram_port_if.master           port_b
);
    localparam logic [ADDR_WIDTH:0] FullLevel = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [ADDR_WIDTH:0]   wptr_q, rptr_q, mem_level;
    logic                  rd_inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q, buf1_q;
    logic [1:0]            buf_cnt_q, tail;
    logic [ADDR_WIDTH+1:0] count_q;
    logic                  flush, full, push, pop, issue;
    logic                  unused_dout;

`ifdef BRAM_STREAM_FIFO_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign mem_level = wptr_q - rptr_q;
    assign full      = (mem_level == FullLevel);
    assign o_s_ready = i_rst_n && !full && !flush;
    assign push      = i_s_valid && o_s_ready;
    assign o_m_valid = (buf_cnt_q != 2'd0);
    assign o_m_data  = buf0_q;
    assign pop       = o_m_valid && i_m_ready;
    assign o_count   = count_q;
    assign tail      = buf_cnt_q - {1'b0, pop};

    // Only fetch when the buffer is guaranteed a free slot on the returning cycle.
    assign issue = (mem_level != '0) &&
                   (({1'b0, buf_cnt_q} + {2'b0, rd_inflight_q} - {2'b0, pop}) < 3'd2);

    assign port_a.we   = push;
    assign port_a.addr = wptr_q[ADDR_WIDTH-1:0];
    assign port_a.din  = i_s_data;
    assign port_b.we   = 1'b0;
    assign port_b.addr = rptr_q[ADDR_WIDTH-1:0];
    assign port_b.din  = '0;
    assign unused_dout = ^port_a.dout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            rd_inflight_q <= 1'b0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            buf_cnt_q     <= 2'd0;
            count_q       <= '0;
        end else if (flush) begin
            // Buffer data is kept so o_m_data holds; only occupancy is cleared.
            wptr_q        <= '0;
            rptr_q        <= '0;
            rd_inflight_q <= 1'b0;
            buf_cnt_q     <= 2'd0;
            count_q       <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (ADDR_WIDTH + 1)'(1);
            if (issue) rptr_q <= rptr_q + (ADDR_WIDTH + 1)'(1);
            rd_inflight_q <= issue;

            if (pop && buf_cnt_q == 2'd2) buf0_q <= buf1_q;
            if (rd_inflight_q) begin
                if (tail == 2'd0) buf0_q <= port_b.dout;
                else              buf1_q <= port_b.dout;
            end
            buf_cnt_q <= tail + {1'b0, rd_inflight_q};

            if (push && !pop)      count_q <= count_q + (ADDR_WIDTH + 2)'(1);
            else if (pop && !push) count_q <= count_q - (ADDR_WIDTH + 2)'(1);
        end
    end
endmodule
